// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//
// Time-multiplexed driver for common-anode seven-segment displays.
// Each digit is selected in turn for 2^REFRESH_BITS clk cycles.
// The top four bits of the dwell counter give a PWM dimming compare.
// The driver also provides per-digit blink, per-digit decimal points,
// leading-zero blanking and an optional full-hex decode.
// All outputs come straight from flops, so the board pins never glitch.
// Every output is registered from the pre-edge scan state, which gives
// one cycle of latency.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   digits      4-bit code per digit; digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit, active high
//   blink_mask  1 = digit blinks with the blink counter MSB
//   lz_blank    1 = suppress leading zeros (digit 0 is never suppressed)
//   brightness  PWM duty (brightness+1)/16; 15 = always lit
//   seg         cathodes {a,b,c,d,e,f,g}, active low
//   dp          decimal point cathode, active low
//   anode       digit enables, active low; one low bit or all high

module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 25,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [REFRESH_BITS-1:0] dwell_q, dwell_d;
    logic [BLINK_BITS-1:0]   blink_cnt_q, blink_cnt_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [3:0]            code_sel;
    logic                  dp_sel;
    logic                  blink_sel;
    logic                  zero_sel;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  blink_phase;
    logic                  lit;
    logic                  code_undef;
    logic                  lz_hit;
    logic                  blank;

    // Active-low segment patterns. In decimal mode only 0-9 and 'A'
    // have shapes; 11-15 fall through to blank.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = (HEX_MODE != 0) ? 7'b1100000 : SEG_OFF;
            4'hC:    s = (HEX_MODE != 0) ? 7'b0110001 : SEG_OFF;
            4'hD:    s = (HEX_MODE != 0) ? 7'b1000010 : SEG_OFF;
            4'hE:    s = (HEX_MODE != 0) ? 7'b0110000 : SEG_OFF;
            4'hF:    s = (HEX_MODE != 0) ? 7'b0111000 : SEG_OFF;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Scan and blink counters.
    always_comb begin
        dwell_d     = dwell_q + REFRESH_BITS'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        if (&dwell_q) begin
            // Explicit wrap keeps idx in range when NUM_DIGITS is not a power of 2.
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // zero_from[i] = digits i..NUM_DIGITS-1 are all code 0.
    always_comb begin : lz_chain
        logic run_zero;
        run_zero  = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero && (digits[4*i +: 4] == 4'd0);
            zero_from[i] = run_zero;
        end
    end

    // Select the per-digit inputs for the digit being scanned.
    always_comb begin
        code_sel  = '0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        zero_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_sel  = digits[4*i +: 4];
                dp_sel    = dp_in[i];
                blink_sel = blink_mask[i];
                zero_sel  = zero_from[i];
            end
        end
    end

    assign blink_phase = blink_cnt_q[BLINK_BITS-1];
    assign lit         = (dwell_q[REFRESH_BITS-1 -: 4] <= brightness);
    assign code_undef  = (HEX_MODE == 0) && (code_sel > 4'd10);
    assign lz_hit      = lz_blank && (idx_q != '0) && zero_sel;
    assign blank       = (blink_sel && blink_phase) || lz_hit || code_undef;

    // A blanked digit keeps its anode low while it is lit. Only the
    // segments and dp go dark, so the scan timing stays the same.
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (lit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    anode_d[i] = 1'b0;
                end
            end
            if (!blank) begin
                seg_d = decode(code_sel);
                dp_d  = ~dp_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            anode_q     <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

    localparam logic [6:0] S0  = 7'b0000001;
    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S3  = 7'b0000110;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] S5  = 7'b0100100;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SB  = 7'b1100000;
    localparam logic [6:0] SC  = 7'b0110001;
    localparam logic [6:0] SD  = 7'b1000010;
    localparam logic [6:0] BLK = 7'h7F;
    localparam logic [11:0] OFF = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [3:0]  brightness;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0] seg1234 [4];

    always #5 clk = ~clk;

    seven_segment_mux #(
        .NUM_DIGITS(4), .REFRESH_BITS(4), .BLINK_BITS(6), .HEX_MODE(0)
    ) dut_dec (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg0), .dp(dp0), .anode(an0)
    );

    seven_segment_mux #(
        .NUM_DIGITS(4), .REFRESH_BITS(4), .BLINK_BITS(6), .HEX_MODE(1)
    ) dut_hex (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg1), .dp(dp1), .anode(an1)
    );

    function automatic logic [11:0] on(input int i, input logic [6:0] s, input logic d);
        logic [3:0] a;
        a    = 4'b1111;
        a[i] = 1'b0;
        return {a, s, d};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) tick();
    endtask

    // Reset is asserted between edges and checked before any edge arrives.
    task automatic restart();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_dec", {an0, seg0, dp0}, OFF);
        chk("reset_hex", {an1, seg1, dp1}, OFF);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        seg1234[0] = S4;
        seg1234[1] = S3;
        seg1234[2] = S2;
        seg1234[3] = S1;

        rst        = 1'b1;
        digits     = 16'h1234;
        dp_in      = 4'b0000;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        brightness = 4'd15;
        #3;
        chk("por_dec", {an0, seg0, dp0}, OFF);
        chk("por_hex", {an1, seg1, dp1}, OFF);

        // Basic scan, full brightness, wraps back to digit 0 at cycle 65.
        restart();
        for (int k = 1; k <= 65; k++) begin
            step_to(k);
            chk("scan", {an0, seg0, dp0}, on(((k - 1) / 16) % 4, seg1234[((k - 1) / 16) % 4], 1'b1));
        end

        // PWM: brightness 3 lights the first 4 of every 16 dwell cycles.
        brightness = 4'd3;
        restart();
        for (int k = 1; k <= 32; k++) begin
            step_to(k);
            if (((k - 1) % 16) <= 3)
                chk("pwm3", {an0, seg0, dp0}, on((k - 1) / 16, seg1234[(k - 1) / 16], 1'b1));
            else
                chk("pwm3_off", {an0, seg0, dp0}, OFF);
        end
        brightness = 4'd0;
        restart();
        for (int k = 1; k <= 16; k++) begin
            step_to(k);
            if (k == 1) chk("pwm0", {an0, seg0, dp0}, on(0, S4, 1'b1));
            else        chk("pwm0_off", {an0, seg0, dp0}, OFF);
        end

        // Blink: with these sizes one scan equals one blink period, so digit 1
        // always falls in phase 0 (shown) and digit 2 always in phase 1 (blank).
        brightness = 4'd15;
        blink_mask = 4'b0110;
        restart();
        for (int k = 1; k <= 128; k++) begin
            int i;
            logic ph;
            i  = ((k - 1) / 16) % 4;
            ph = (((k - 1) >> 5) & 1) == 1;
            step_to(k);
            chk("blink", {an0, seg0, dp0}, on(i, (blink_mask[i] && ph) ? BLK : seg1234[i], 1'b1));
        end
        blink_mask = 4'b0000;

        // Leading-zero blanking.
        lz_blank = 1'b1;
        digits   = 16'h0050;
        restart();
        step_to(1);  chk("lz50_d0", {an0, seg0, dp0}, on(0, S0, 1'b1));
        step_to(17); chk("lz50_d1", {an0, seg0, dp0}, on(1, S5, 1'b1));
        step_to(33); chk("lz50_d2", {an0, seg0, dp0}, on(2, BLK, 1'b1));
        step_to(49); chk("lz50_d3", {an0, seg0, dp0}, on(3, BLK, 1'b1));
        digits = 16'h0000;
        restart();
        step_to(1);  chk("lz00_d0", {an0, seg0, dp0}, on(0, S0, 1'b1));
        step_to(17); chk("lz00_d1", {an0, seg0, dp0}, on(1, BLK, 1'b1));
        step_to(33); chk("lz00_d2", {an0, seg0, dp0}, on(2, BLK, 1'b1));
        step_to(49); chk("lz00_d3", {an0, seg0, dp0}, on(3, BLK, 1'b1));
        lz_blank = 1'b0;
        restart();
        step_to(1);  chk("nolz_d0", {an0, seg0, dp0}, on(0, S0, 1'b1));
        step_to(17); chk("nolz_d1", {an0, seg0, dp0}, on(1, S0, 1'b1));
        step_to(33); chk("nolz_d2", {an0, seg0, dp0}, on(2, S0, 1'b1));
        step_to(49); chk("nolz_d3", {an0, seg0, dp0}, on(3, S0, 1'b1));

        // Hex decode and decimal point; the decimal build blanks codes 11-15 and their dp.
        digits = 16'hABCD;
        dp_in  = 4'b0100;
        restart();
        step_to(1);  chk("hex_d0", {an1, seg1, dp1}, on(0, SD, 1'b1));
                     chk("dec_d0", {an0, seg0, dp0}, on(0, BLK, 1'b1));
        step_to(17); chk("hex_d1", {an1, seg1, dp1}, on(1, SC, 1'b1));
                     chk("dec_d1", {an0, seg0, dp0}, on(1, BLK, 1'b1));
        step_to(33); chk("hex_d2", {an1, seg1, dp1}, on(2, SB, 1'b0));
                     chk("dec_d2", {an0, seg0, dp0}, on(2, BLK, 1'b1));
        step_to(49); chk("hex_d3", {an1, seg1, dp1}, on(3, SA, 1'b1));
                     chk("dec_d3", {an0, seg0, dp0}, on(3, SA, 1'b1));
        dp_in = 4'b0000;

        // Mid-scan reset at idx=2, dwell=7, then restart from digit 0.
        digits = 16'h1234;
        restart();
        step_to(39);
        chk("pre_reset", {an0, seg0, dp0}, on(2, S2, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {an0, seg0, dp0}, OFF);
        #2;
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("post_reset", {an0, seg0, dp0}, on(0, S4, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
